// File: rtl/jtkicker_obj_pkg.sv
// Shared definitions for the Kicker object line scanner.
// Holds the scanner state encodings, the object-table word offsets, the per-line
// draw limit and the packed draw-request entry that travels through the queue.
package jtkicker_obj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RDY   = 3'd1,
    ST_TEST  = 3'd2,
    ST_FETCH = 3'd3,
    ST_PUSH  = 3'd4
  } obj_state_t;

  // Each table entry spans two RAM words: even = {ypos, attr}, odd = {code, xpos}
  // (high byte, low byte).
  localparam logic OFS_ATTR_YPOS = 1'b0;
  localparam logic OFS_XPOS_CODE = 1'b1;

  // Maximum draw requests per line when the limiter is built in.
  localparam int OBJ_LINE_LIMIT = 8;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] code;
    logic [7:0] xpos;
    logic [3:0] v;
  } obj_entry_t;

  localparam int OBJ_ENTRY_W = $bits(obj_entry_t);

  // Line offset of the object relative to its top row, modulo 256, so objects
  // straddling the top of the frame wrap naturally.
  function automatic logic [7:0] obj_ydiff(input logic [7:0] vrender,
                                           input logic [7:0] ypos);
    return vrender - ypos;
  endfunction

endpackage

// File: rtl/jtkicker_obj_fifo.sv
// Two-entry queue for object draw requests.
// Ports: i_push/i_push_dat write, i_pop removes the head, i_flush empties it,
//        o_head/o_empty/o_full describe the current state. Head is a registered slot.
// A push is accepted while full if a pop happens on the same cycle; flush wins
// over push and pop. Callers gate i_push/i_pop/i_flush with their clock enable.
module jtkicker_obj_fifo #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_cnt == 2'd0);
  assign o_full    = (r_cnt == 2'd2);
  assign o_head    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  // When full, the slot being written is the one being popped this cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop_ok) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt <= r_cnt + 2'(w_push_ok) - 2'(w_pop_ok);
    end
  end

endmodule

// File: rtl/jtkicker_obj_scan.sv
// Object line scanner: walks the object table once per line, queues the objects
// that cover the line being rendered and hands them out on a valid/ready channel.
// Ports: clk/rst_n/cen2; hinit + vrender start a line; scan_addr/low_dout/hi_dout
//        read the object RAM; dr_* is the draw request channel; busy, ovf status.
// Build option: JTKICKER_OBJ_LIMIT_EN caps requests per line and drives ovf;
// without it there is no cap and ovf is constant 0.
module jtkicker_obj_scan
  import jtkicker_obj_pkg::*;
#(
  parameter int OBJMAX = 32,
  parameter int OBJH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen2,
  input  logic       hinit,
  input  logic [7:0] vrender,
  output logic [5:0] scan_addr,
  input  logic [7:0] low_dout,
  input  logic [7:0] hi_dout,
  output logic       dr_valid,
  input  logic       dr_ready,
  output logic [7:0] dr_attr,
  output logic [7:0] dr_code,
  output logic [7:0] dr_xpos,
  output logic [3:0] dr_v,
  output logic       busy,
  output logic       ovf
);

  // The 6-bit address leaves 5 bits of entry index; the final index is
  // truncated to that width.
  localparam logic [4:0] LAST_IDX = 5'(OBJMAX - 1);

  obj_state_t r_state;
  logic [5:0] r_scan_addr;
  logic       r_hinit_d;
  logic       r_hflag;
  logic       r_wait;
  logic [7:0] r_attr;
  logic [7:0] r_xpos;
  logic [7:0] r_code;
  logic [3:0] r_v;

  logic       w_hinit_rise;
  logic       w_hit;
  logic [7:0] w_ydiff;
  logic       w_in_zone;
  logic       w_limit_hit;
  logic       w_take;
  logic       w_last;
  logic [4:0] w_next_idx;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_can_push;
  logic       w_push;
  logic       w_pop;
  logic       w_flush;
  obj_entry_t w_push_dat;
  obj_entry_t w_head;

  // hinit may be shorter than a cen2 period: its rising edge is remembered
  // until the next enabled cycle, and also acted on directly if that cycle is
  // enabled, so a pulse of any width starts exactly one scan.
  assign w_hinit_rise = hinit & ~r_hinit_d;
  assign w_hit        = w_hinit_rise | r_hflag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hinit_d <= 1'b0;
      r_hflag   <= 1'b0;
    end else begin
      r_hinit_d <= hinit;
      if (cen2) begin
        r_hflag <= 1'b0;
      end else if (w_hinit_rise) begin
        r_hflag <= 1'b1;
      end
    end
  end

  assign w_ydiff    = obj_ydiff(vrender, hi_dout);
  assign w_in_zone  = (w_ydiff < 8'(OBJH));
  assign w_take     = w_in_zone & ~w_limit_hit;
  assign w_last     = (r_scan_addr[5:1] == LAST_IDX);
  assign w_next_idx = r_scan_addr[5:1] + 5'd1;

  // Full implies non-empty, so a ready sink always frees a slot this cycle.
  assign w_can_push = ~w_fifo_full | dr_ready;
  assign w_push     = cen2 & ~w_hit & (r_state == ST_PUSH) & w_can_push;
  assign w_pop      = cen2 & dr_ready;
  assign w_flush    = cen2 & w_hit & (r_state != ST_IDLE);

  assign w_push_dat = '{attr: r_attr, code: r_code, xpos: r_xpos, v: r_v};

`ifdef JTKICKER_OBJ_LIMIT_EN
  logic [3:0] r_line_cnt;
  logic       r_ovf;

  assign w_limit_hit = (r_line_cnt >= 4'(OBJ_LINE_LIMIT));
  assign ovf         = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= 4'd0;
      r_ovf      <= 1'b0;
    end else if (cen2) begin
      if (w_hit) begin
        r_line_cnt <= 4'd0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_push) begin
          r_line_cnt <= r_line_cnt + 4'd1;
        end
        // An in-zone entry found after the cap is skipped but flagged.
        if (r_state == ST_TEST && w_in_zone && w_limit_hit) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end
`else
  assign w_limit_hit = 1'b0;
  assign ovf         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_scan_addr <= 6'd0;
      r_wait      <= 1'b0;
      r_attr      <= 8'd0;
      r_xpos      <= 8'd0;
      r_code      <= 8'd0;
      r_v         <= 4'd0;
    end else if (cen2) begin
      if (w_hit) begin
        // Line start, or abort of a scan in progress: restart at entry 0.
        r_scan_addr <= 6'd0;
        r_wait      <= 1'b0;
        r_state     <= ST_RDY;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_RDY: begin
            // RAM registers the new address during this cycle.
            r_state <= ST_TEST;
          end
          ST_TEST: begin
            if (w_take) begin
              r_attr      <= low_dout;
              r_v         <= w_ydiff[3:0];
              r_scan_addr <= {r_scan_addr[5:1], OFS_XPOS_CODE};
              r_wait      <= 1'b1;
              r_state     <= ST_FETCH;
            end else if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_scan_addr <= {w_next_idx, OFS_ATTR_YPOS};
              r_state     <= ST_RDY;
            end
          end
          ST_FETCH: begin
            // First cycle lets the RAM pick up the odd address; the second
            // captures the odd word.
            if (r_wait) begin
              r_wait <= 1'b0;
            end else begin
              r_xpos  <= low_dout;
              r_code  <= hi_dout;
              r_state <= ST_PUSH;
            end
          end
          ST_PUSH: begin
            if (w_can_push) begin
              if (w_last) begin
                r_state <= ST_IDLE;
              end else begin
                r_scan_addr <= {w_next_idx, OFS_ATTR_YPOS};
                r_state     <= ST_RDY;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  jtkicker_obj_fifo #(
    .W(OBJ_ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_head     (w_head)
  );

  assign scan_addr = r_scan_addr;
  assign dr_valid  = ~w_fifo_empty;
  assign dr_attr   = w_head.attr;
  assign dr_code   = w_head.code;
  assign dr_xpos   = w_head.xpos;
  assign dr_v      = w_head.v;
  assign busy      = (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule
